// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg
//   Shared definitions for the approximate multiplier pipeline.
//   - W_DEF, APPROX_COLS_DEF : default operand width and OR-merged band width
//   - mode_e                 : per-beat arithmetic mode
//   - approx_combine()       : S3 column merge for the default configuration,
//                              usable by any model that needs the same merge
package approx_mult_pkg;

   localparam int W_DEF           = 32;
   localparam int APPROX_COLS_DEF = 32;
   localparam int H_DEF           = W_DEF / 2;
   localparam int BAND_HI_DEF     = H_DEF + APPROX_COLS_DEF;

   typedef enum logic {
      MODE_APPROX  = 1'b0,
      MODE_PRECISE = 1'b1
   } mode_e;

   // Merges the four half-width partial products into a 2W result.
   // Columns below H come from P1 alone, the band [H, H+APPROX_COLS) is an
   // OR of the column bits, and columns above the band are summed exactly
   // with no carry entering from the band.
   function automatic logic [2*W_DEF-1:0] approx_combine(
      input logic [W_DEF-1:0] p1,
      input logic [W_DEF-1:0] p2,
      input logic [W_DEF-1:0] p3,
      input logic [W_DEF-1:0] p4,
      input mode_e            mode
   );
      logic [2*W_DEF-1:0] t1, t2, t3, t4, or_all, hi_sum, y;
      t1 = {{W_DEF{1'b0}}, p1};
      t2 = {{H_DEF{1'b0}}, p2, {H_DEF{1'b0}}};
      t3 = {{H_DEF{1'b0}}, p3, {H_DEF{1'b0}}};
      t4 = {p4, {W_DEF{1'b0}}};
      if (mode == MODE_PRECISE) begin
         y = t1 + t2 + t3 + t4;
      end else begin
         or_all = t1 | t2 | t3 | t4;
         hi_sum = (t1 >> BAND_HI_DEF) + (t2 >> BAND_HI_DEF)
                + (t3 >> BAND_HI_DEF) + (t4 >> BAND_HI_DEF);
         y = hi_sum << BAND_HI_DEF;
         for (int c = 0; c < BAND_HI_DEF && c < 2*W_DEF; c++) begin
            y[c] = (c < H_DEF) ? t1[c] : or_all[c];
         end
      end
      return y;
   endfunction

endpackage

// File: rtl/approx_combine_cols.sv
// approx_combine_cols
//   Combinational S3 merge of four partial products into a 2W product.
//   Ports:
//     p1..p4  in  W   aL*bL, aH*bL, aL*bH, aH*bH
//     precise in  1   1 = exact sum, 0 = OR-merged band
//     y       out 2W  merged product
module approx_combine_cols #(
   parameter int W           = 32,
   parameter int APPROX_COLS = 32
) (
   input  logic [W-1:0]   p1,
   input  logic [W-1:0]   p2,
   input  logic [W-1:0]   p3,
   input  logic [W-1:0]   p4,
   input  logic           precise,
   output logic [2*W-1:0] y
);
   localparam int H       = W / 2;
   localparam int BAND_HI = H + APPROX_COLS;

   function automatic logic [2*W-1:0] col_mask(input int lo, input int hi);
      logic [2*W-1:0] m;
      for (int c = 0; c < 2*W; c++) begin
         m[c] = (c >= lo) && (c < hi);
      end
      return m;
   endfunction

   localparam logic [2*W-1:0] LOW_MASK  = col_mask(0, H);
   localparam logic [2*W-1:0] BAND_MASK = col_mask(H, BAND_HI);

   logic [2*W-1:0] t1, t2, t3, t4;
   logic [2*W-1:0] exact, or_all, hi_part, approx;

   assign t1 = {{W{1'b0}}, p1};
   assign t2 = {{(W-H){1'b0}}, p2, {H{1'b0}}};
   assign t3 = {{(W-H){1'b0}}, p3, {H{1'b0}}};
   assign t4 = {p4, {W{1'b0}}};

   assign exact  = t1 + t2 + t3 + t4;
   assign or_all = t1 | t2 | t3 | t4;

   // Columns above the band form an independent adder whose carry-in is 0;
   // its carry out of the top column simply falls off.
   generate
      if (BAND_HI < 2*W) begin : g_hi
         logic [2*W-BAND_HI-1:0] hi_sum;
         assign hi_sum  = t1[2*W-1:BAND_HI] + t2[2*W-1:BAND_HI]
                        + t3[2*W-1:BAND_HI] + t4[2*W-1:BAND_HI];
         assign hi_part = {hi_sum, {BAND_HI{1'b0}}};
      end else begin : g_no_hi
         assign hi_part = '0;
      end
   endgenerate

   assign approx = (t1 & LOW_MASK) | (or_all & BAND_MASK) | hi_part;
   assign y      = precise ? exact : approx;

endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe
//   Three-stage W x W unsigned multiplier with per-beat exact/approximate mode
//   and valid/ready handshakes on both sides.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     in_valid/in_ready input handshake; in_a, in_b, in_precise sampled on accept
//     out_valid/out_ready output handshake; out_y (2W), out_precise
//     approx_cnt        saturating count of accepted approximate beats
//     cnt_clr           synchronous clear of approx_cnt (wins over counting)
module approx_mult_pipe
   import approx_mult_pkg::*;
#(
   parameter int W           = W_DEF,
   parameter int APPROX_COLS = APPROX_COLS_DEF,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic             in_precise,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_y,
   output logic             out_precise,
   output logic [CNT_W-1:0] approx_cnt,
   input  logic             cnt_clr
);
   localparam int H = W / 2;

   logic           stall, advance, accept;
   logic           s1_valid, s2_valid;
   logic [W-1:0]   s1_a, s1_b;
   mode_e          s1_mode, s2_mode;
   logic [W-1:0]   pp1, pp2, pp3, pp4;
   logic [W-1:0]   s2_p1, s2_p2, s2_p3, s2_p4;
   logic [2*W-1:0] comb_y;

   // A single enable moves every stage together; only a held output beat
   // stops it, so bubbles further down never block new input.
   assign stall    = out_valid && !out_ready;
   assign advance  = !stall;
   assign in_ready = advance;
   assign accept   = in_valid && in_ready;

   assign pp1 = {{(W-H){1'b0}}, s1_a[H-1:0]} * {{(W-H){1'b0}}, s1_b[H-1:0]};
   assign pp2 = {{H{1'b0}}, s1_a[W-1:H]}     * {{(W-H){1'b0}}, s1_b[H-1:0]};
   assign pp3 = {{(W-H){1'b0}}, s1_a[H-1:0]} * {{H{1'b0}}, s1_b[W-1:H]};
   assign pp4 = {{H{1'b0}}, s1_a[W-1:H]}     * {{H{1'b0}}, s1_b[W-1:H]};

   // NOTE: state uses non-blocking assignments so every stage samples the
   // pre-edge value of the stage before it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else if (advance) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
      end
   end

   // NOTE: S1/S2 payload registers are not reset; the valid bits above
   // already mark their contents as meaningless after reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_a    <= in_a;
         s1_b    <= in_b;
         s1_mode <= mode_e'(in_precise);
      end
      if (advance && s1_valid) begin
         s2_p1   <= pp1;
         s2_p2   <= pp2;
         s2_p3   <= pp3;
         s2_p4   <= pp4;
         s2_mode <= s1_mode;
      end
   end

   approx_combine_cols #(
      .W           (W),
      .APPROX_COLS (APPROX_COLS)
   ) u_combine (
      .p1      (s2_p1),
      .p2      (s2_p2),
      .p3      (s2_p3),
      .p4      (s2_p4),
      .precise (s2_mode == MODE_PRECISE),
      .y       (comb_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_y       <= '0;
         out_precise <= 1'b0;
      end else if (advance && s2_valid) begin
         out_y       <= comb_y;
         out_precise <= (s2_mode == MODE_PRECISE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         approx_cnt <= '0;
      end else if (cnt_clr) begin
         approx_cnt <= '0;
      end else if (accept && !in_precise && (approx_cnt != {CNT_W{1'b1}})) begin
         approx_cnt <= approx_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe
//   Drives three configurations of approx_mult_pipe from one stimulus stream:
//     u_main  W=32 APPROX_COLS=32 CNT_W=16
//     u_alt   W=32 APPROX_COLS=0  CNT_W=2  (approximate must equal exact)
//     u_small W=8  APPROX_COLS=3  CNT_W=4  (operands are in_a[7:0], in_b[7:0])
//   A three-slot beat model and a column-by-column arithmetic reference
//   supply every expected value.
module tb_approx_mult_pipe;
   import approx_mult_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_precise = 1'b0;
   logic        out_ready = 1'b1;
   logic        cnt_clr = 1'b0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;

   logic        rdy_m, rdy_a, rdy_s;
   logic        ov_m, ov_a, ov_s;
   logic        op_m, op_a, op_s;
   logic [63:0] y_m, y_a;
   logic [15:0] y_s;
   logic [15:0] cnt_m;
   logic [1:0]  cnt_a;
   logic [3:0]  cnt_s;

   always #5 clk = ~clk;

   approx_mult_pipe #(.W(32), .APPROX_COLS(32), .CNT_W(16)) u_main (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_m),
      .in_a(in_a), .in_b(in_b), .in_precise(in_precise),
      .out_valid(ov_m), .out_ready(out_ready), .out_y(y_m), .out_precise(op_m),
      .approx_cnt(cnt_m), .cnt_clr(cnt_clr));

   approx_mult_pipe #(.W(32), .APPROX_COLS(0), .CNT_W(2)) u_alt (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
      .in_a(in_a), .in_b(in_b), .in_precise(in_precise),
      .out_valid(ov_a), .out_ready(out_ready), .out_y(y_a), .out_precise(op_a),
      .approx_cnt(cnt_a), .cnt_clr(cnt_clr));

   approx_mult_pipe #(.W(8), .APPROX_COLS(3), .CNT_W(4)) u_small (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
      .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_precise(in_precise),
      .out_valid(ov_s), .out_ready(out_ready), .out_y(y_s), .out_precise(op_s),
      .approx_cnt(cnt_s), .cnt_clr(cnt_clr));

   typedef struct {
      bit          v;
      logic [31:0] a;
      logic [31:0] b;
      bit          p;
      bit          has_gold;
      logic [63:0] gold;
   } beat_t;

   beat_t       pipe [3];
   int          n_checks = 0;
   int          n_errors = 0;
   int          exp_cnt_m, exp_cnt_a, exp_cnt_s;
   bit          cur_has_gold;
   logic [63:0] cur_gold;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Product from the column rules: low half from P1, OR inside the band,
   // ripple-carry addition above it starting from carry 0.
   function automatic logic [63:0] ref_y(input logic [31:0] a_in, input logic [31:0] b_in,
                                         input bit prec, input int w, input int ac);
      logic [63:0] a, b, wmask, hmask, y;
      logic [63:0] t [4];
      int          h, n, carry;
      h     = w / 2;
      wmask = (64'd1 << w) - 64'd1;
      hmask = (64'd1 << h) - 64'd1;
      a     = {32'd0, a_in} & wmask;
      b     = {32'd0, b_in} & wmask;
      if (prec) return a * b;
      t[0] = (a & hmask) * (b & hmask);
      t[1] = ((a >> h) * (b & hmask)) << h;
      t[2] = ((a & hmask) * (b >> h)) << h;
      t[3] = ((a >> h) * (b >> h)) << w;
      y     = '0;
      carry = 0;
      for (int c = 0; c < 2*w; c++) begin
         n = 0;
         for (int k = 0; k < 4; k++) n += int'(t[k][c]);
         if (c < h) begin
            y[c] = t[0][c];
         end else if (c < h + ac) begin
            y[c] = (n != 0);
         end else begin
            n     += carry;
            y[c]  = n[0];
            carry = n >> 1;
         end
      end
      return y;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) pipe[i].v = 1'b0;
      exp_cnt_m = 0;
      exp_cnt_a = 0;
      exp_cnt_s = 0;
   endtask

   task automatic compare_outputs();
      bit    exp_rdy;
      beat_t bt;
      exp_rdy = !(pipe[2].v && !out_ready);
      check("m.in_ready", rdy_m, exp_rdy);
      check("a.in_ready", rdy_a, exp_rdy);
      check("s.in_ready", rdy_s, exp_rdy);
      check("m.out_valid", ov_m, pipe[2].v);
      check("a.out_valid", ov_a, pipe[2].v);
      check("s.out_valid", ov_s, pipe[2].v);
      if (pipe[2].v) begin
         bt = pipe[2];
         check("m.out_y", y_m, ref_y(bt.a, bt.b, bt.p, 32, 32));
         check("a.out_y_exact", y_a, {32'd0, bt.a} * {32'd0, bt.b});
         check("s.out_y", y_s, ref_y(bt.a, bt.b, bt.p, 8, 3));
         check("m.out_precise", op_m, bt.p);
         check("a.out_precise", op_a, bt.p);
         check("s.out_precise", op_s, bt.p);
         if (bt.has_gold) check("m.out_y_directed", y_m, bt.gold);
      end
      check("m.approx_cnt", cnt_m, exp_cnt_m);
      check("a.approx_cnt", cnt_a, exp_cnt_a);
      check("s.approx_cnt", cnt_s, exp_cnt_s);
   endtask

   // Entered and left at posedge+1 with inputs already driven.
   task automatic cycle(output bit accepted);
      bit exp_rdy;
      @(negedge clk);
      compare_outputs();
      exp_rdy  = !(pipe[2].v && !out_ready);
      accepted = rst_n && in_valid && exp_rdy;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         if (cnt_clr) begin
            exp_cnt_m = 0;
            exp_cnt_a = 0;
            exp_cnt_s = 0;
         end else if (accepted && !in_precise) begin
            if (exp_cnt_m < 65535) exp_cnt_m++;
            if (exp_cnt_a < 3)     exp_cnt_a++;
            if (exp_cnt_s < 15)    exp_cnt_s++;
         end
         if (exp_rdy) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{accepted, in_a, in_b, in_precise, cur_has_gold, cur_gold};
         end
      end
      #1;
   endtask

   task automatic cycles(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(acc);
   endtask

   task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b, input bit p,
                        input bit hg, input logic [63:0] g);
      in_valid     = v;
      in_a         = a;
      in_b         = b;
      in_precise   = p;
      cur_has_gold = hg;
      cur_gold     = g;
   endtask

   task automatic drive_idle();
      drive(1'b0, $urandom, $urandom, 1'($urandom), 1'b0, '0);
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input bit p,
                       input bit hg, input logic [63:0] g);
      bit acc;
      int tries;
      drive(1'b1, a, b, p, hg, g);
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 50) begin
         cycle(acc);
         tries++;
      end
      check("send_accepted", acc, 1'b1);
      drive_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ra [8];
      logic [31:0] rb [8];
      bit          rp [8];
      logic [31:0] a, b;
      bit          acc;
      int          idx;

      // Package merge function against the column reference.
      for (int i = 0; i < 8; i++) begin
         a = (i == 0) ? 32'hFFFF_FFFF : $urandom;
         b = (i == 0) ? 32'hFFFF_FFFF : $urandom;
         check("pkg.approx_combine",
               approx_combine(a[15:0] * b[15:0], a[31:16] * b[15:0],
                              a[15:0] * b[31:16], a[31:16] * b[31:16], mode_e'(i[0])),
               ref_y(a, b, i[0], 32, 32));
      end

      model_reset();
      drive_idle();
      cycles(3);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycles(2);

      // Small operands in both modes, then the two half-boundary patterns.
      send(32'd3, 32'd5, 1'b1, 1'b1, 64'd15);
      send(32'd3, 32'd5, 1'b0, 1'b1, 64'd15);
      send(32'h0001_0001, 32'h0001_0001, 1'b1, 1'b1, 64'h0000_0001_0002_0001);
      send(32'h0001_0001, 32'h0001_0001, 1'b0, 1'b1, 64'h0000_0001_0001_0001);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFE_0000_0001);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFE_FFFF_FFFF_0001);
      cycles(5);

      // Eight back-to-back beats with the consumer stalling three cycles.
      for (int i = 0; i < 8; i++) begin
         ra[i] = $urandom;
         rb[i] = $urandom;
         rp[i] = 1'($urandom);
      end
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         out_ready = !(c >= 4 && c <= 6);
         if (idx < 8) drive(1'b1, ra[idx], rb[idx], rp[idx], 1'b0, '0);
         else         drive_idle();
         cycle(acc);
         if (acc) idx++;
      end
      out_ready = 1'b1;
      check("burst_accepted", idx, 8);
      cycles(4);

      // Random traffic with random back-pressure and occasional clears.
      for (int c = 0; c < 300; c++) begin
         a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         drive($urandom_range(0, 9) < 7, a, b, 1'($urandom), 1'b0, '0);
         out_ready = $urandom_range(0, 3) != 0;
         cnt_clr   = $urandom_range(0, 19) == 0;
         cycle(acc);
      end
      cnt_clr   = 1'b0;
      out_ready = 1'b1;
      drive_idle();
      cycles(5);

      // Reset with three beats in flight.
      send($urandom, $urandom, 1'b0, 1'b0, '0);
      send($urandom, $urandom, 1'b1, 1'b0, '0);
      send($urandom, $urandom, 1'b0, 1'b0, '0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst.m.out_valid", ov_m, 1'b0);
      check("rst.a.out_valid", ov_a, 1'b0);
      check("rst.s.out_valid", ov_s, 1'b0);
      check("rst.m.out_y", y_m, 64'd0);
      check("rst.s.out_y", y_s, 16'd0);
      check("rst.m.out_precise", op_m, 1'b0);
      check("rst.m.approx_cnt", cnt_m, 16'd0);
      check("rst.a.approx_cnt", cnt_a, 2'd0);
      model_reset();
      cycles(2);
      rst_n = 1'b1;
      cycles(3);
      send(32'd3, 32'd5, 1'b0, 1'b1, 64'd15);
      cycles(4);

      // Counter saturation and clear-over-count priority.
      cnt_clr = 1'b1;
      cycles(1);
      cnt_clr = 1'b0;
      for (int i = 0; i < 5; i++) send($urandom, $urandom, 1'b0, 1'b0, '0);
      check("a.approx_cnt_saturated", cnt_a, 2'd3);
      check("m.approx_cnt_five", cnt_m, 16'd5);
      cnt_clr = 1'b1;
      send($urandom, $urandom, 1'b0, 1'b0, '0);
      cnt_clr = 1'b0;
      check("a.approx_cnt_cleared", cnt_a, 2'd0);
      check("m.approx_cnt_cleared", cnt_m, 16'd0);
      cycles(5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
